// File: rtl/lookup_bank_ctrl.sv
// Ping-pong bank controller for the two-bank gamma/lookup RAM: host writes and
// identity fills target the shadow bank; a commit swaps banks at the next frame_start.
module lookup_bank_ctrl #(
   parameter int PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                  pixclk,
   input  logic                  resetb,
   input  logic                  frame_start,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [PIXEL_WIDTH-1:0] host_data,
   output logic                  host_rdy,
   input  logic                  commit,
   input  logic                  init_identity,
   output logic                  ram_we,
   output logic [ADDR_WIDTH:0]   ram_addr,
   output logic [PIXEL_WIDTH-1:0] ram_data,
   output logic                  active_bank,
   output logic                  commit_pending,
   output logic                  busy,
   output logic                  swap_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam int SHIFT = ADDR_WIDTH - PIXEL_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   logic [1:0]             state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  fill_cnt_reg;
   logic                   host_rdy_reg;
   logic                   ram_we_reg;
   logic [ADDR_WIDTH:0]    ram_addr_reg;
   logic [PIXEL_WIDTH-1:0] ram_data_reg;
   logic                   active_bank_reg;
   logic                   commit_pending_reg;
   logic                   swap_done_reg;

   logic                   accept;
   logic                   fill_last;
   logic [ADDR_WIDTH-1:0]  fill_idx_inc;
   logic [ADDR_WIDTH-1:0]  fill_shift;

   // host_rdy is low for the first cycle after reset release, so inputs there are ignored
   assign accept       = (state_reg == ST_IDLE) && host_rdy_reg;
   assign fill_last    = (fill_cnt_reg == LAST_IDX);
   assign fill_idx_inc = fill_cnt_reg + ADDR_WIDTH'(1);
   assign fill_shift   = fill_idx_inc >> SHIFT;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept && init_identity)
               state_next = ST_FILL;
            else if (accept && commit)
               state_next = ST_WAIT;
         end
         ST_FILL: begin
            // a commit arriving on the very last fill cycle still arms the swap
            if (fill_last)
               state_next = (commit_pending_reg || commit) ? ST_WAIT : ST_IDLE;
         end
         ST_WAIT: begin
            if (frame_start)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixclk) begin
      if (!resetb) begin
         state_reg          <= ST_IDLE;
         fill_cnt_reg       <= '0;
         host_rdy_reg       <= 1'b0;
         ram_we_reg         <= 1'b0;
         ram_addr_reg       <= '0;
         ram_data_reg       <= '0;
         active_bank_reg    <= 1'b0;
         commit_pending_reg <= 1'b0;
         swap_done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         host_rdy_reg  <= (state_next == ST_IDLE);
         ram_we_reg    <= 1'b0;
         swap_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept && init_identity) begin
                  // entry 0 is launched here so entry k lands k+1 cycles after the request
                  fill_cnt_reg <= '0;
                  ram_we_reg   <= 1'b1;
                  ram_addr_reg <= {~active_bank_reg, {ADDR_WIDTH{1'b0}}};
                  ram_data_reg <= '0;
               end else if (accept) begin
                  if (host_we) begin
                     ram_we_reg   <= 1'b1;
                     ram_addr_reg <= {~active_bank_reg, host_addr};
                     ram_data_reg <= host_data;
                  end
                  if (commit)
                     commit_pending_reg <= 1'b1;
               end
            end
            ST_FILL: begin
               if (commit)
                  commit_pending_reg <= 1'b1;
               if (!fill_last) begin
                  fill_cnt_reg <= fill_idx_inc;
                  ram_we_reg   <= 1'b1;
                  ram_addr_reg <= {~active_bank_reg, fill_idx_inc};
                  ram_data_reg <= fill_shift[PIXEL_WIDTH-1:0];
               end
            end
            ST_WAIT: begin
               if (frame_start) begin
                  active_bank_reg    <= ~active_bank_reg;
                  commit_pending_reg <= 1'b0;
                  swap_done_reg      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign host_rdy       = host_rdy_reg;
   assign ram_we         = ram_we_reg;
   assign ram_addr       = ram_addr_reg;
   assign ram_data       = ram_data_reg;
   assign active_bank    = active_bank_reg;
   assign commit_pending = commit_pending_reg;
   assign busy           = (state_reg == ST_FILL);
   assign swap_done      = swap_done_reg;

endmodule

// File: doc/lookup_bank_ctrl.md
# lookup_bank_ctrl

Ping-pong bank controller for the gamma/lookup RAM in the pixel pipeline. It owns the single write port of a two-bank lookup RAM (2 × 2^ADDR_WIDTH entries). Host writes and an identity-fill sequencer go into the shadow bank. A host commit swaps banks only at the next frame boundary, so the pixel-side lookup never sees a half-written table mid-frame.

## Interface
- PIXEL_WIDTH, 8, lookup entry width
- ADDR_WIDTH, 10, entries per bank = 2^ADDR_WIDTH; must be ≥ PIXEL_WIDTH

Ports:
- pixclk  in  1  clock; the only clock
- resetb  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at each frame boundary
- host_we  in  1  host write strobe
- host_addr  in  ADDR_WIDTH  shadow-bank entry index
- host_data  in  PIXEL_WIDTH  entry value
- host_rdy  out  1  registered; host write/commit/init accepted when high
- commit  in  1  pulse; request bank swap at next frame_start
- init_identity  in  1  pulse; fill shadow bank with identity ramp
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH+1  {bank, index}
- ram_data  out  PIXEL_WIDTH  RAM write data
- active_bank  out  1  bank read by the pixel datapath
- commit_pending  out  1  swap armed, waiting for frame_start
- busy  out  1  identity fill in progress
- swap_done  out  1  one-cycle pulse when the banks swap

## Operation
- Reset (resetb=0 at a pixclk edge) sets the state to IDLE.
  - active_bank=0, ram_we=0, ram_addr=0, ram_data=0, host_rdy=0, commit_pending=0, busy=0, swap_done=0.
  - Fill counter resets to 0.
- States:
  - IDLE
    - host_we → one write to {~active_bank, host_addr}.
    - init_identity → FILL.
    - commit → WAIT_SWAP.
  - FILL
    - Writes entry i = counter, data = i >> (ADDR_WIDTH−PIXEL_WIDTH), to {~active_bank, i}.
    - Counter increments 0 … 2^ADDR_WIDTH−1.
    - After the last entry: WAIT_SWAP if commit_pending, else IDLE.
  - WAIT_SWAP
    - frame_start → toggle active_bank, clear commit_pending, pulse swap_done, go to IDLE.
- host_rdy is registered as (next_state == IDLE). Inputs qualify only when host_rdy=1; the one exception is commit during FILL.
- host_we with host_rdy=0 is silently dropped.
- Same-cycle priorities in IDLE:
  - init_identity > commit.
  - init_identity together with host_we: the write is absorbed, since the fill overwrites every entry.
  - commit together with host_we: the write is performed, then WAIT_SWAP.
- commit during FILL sets commit_pending on the next cycle; the swap follows the fill.
- Ignored inputs:
  - init_identity or commit during WAIT_SWAP.
  - frame_start in IDLE or FILL.
  - frame_start in the same cycle as commit: that edge does not swap.
- Reset mid-FILL aborts the fill; shadow contents are unspecified and active_bank=0.

## Timing
- Host write accepted at cycle n → ram_we=1, ram_addr={~active_bank, host_addr}, ram_data=host_data at n+1 only.
- Identity fill, init_identity at n:
  - busy=1 and host_rdy=0 from n+1 through n+2^ADDR_WIDTH.
  - Entry k written at n+1+k.
  - ram_we=0 and busy=0 at n+2^ADDR_WIDTH+1.
  - host_rdy=1 at n+2^ADDR_WIDTH+1 when no commit is pending.
- commit accepted at n → commit_pending=1 and host_rdy=0 from n+1.
- frame_start at m in WAIT_SWAP (m ≥ n+1) → active_bank toggles, swap_done=1, commit_pending=0, host_rdy=1 at m+1.
- No RAM write occurs in a swap cycle. ram_we is never high in WAIT_SWAP.

## Test plan
- Reset, then idle: after resetb rises, host_rdy=1 next cycle and all other outputs 0. Hold resetb=0 with host_we=1 → no ram_we.
- Host write + commit: write addr 5 / data 0x3C at n → ram_addr=0x405, ram_data=0x3C at n+1. commit at n+3, frame_start at n+10 → active_bank=1 and swap_done=1 at n+11, host_rdy=1.
- Identity fill: init_identity at n → 1024 writes over n+1..n+1024. Entry 1023 → ram_addr=0x7FF, data 0xFF. Entry 6 → data 0x01. busy falls at n+1025. host_we during the fill is dropped.
- Commit during fill: commit at n+100 → commit_pending=1 at n+101. frame_start at n+500 causes no swap. First frame_start after n+1024 swaps banks one cycle later.
- Simultaneous events:
  - commit and frame_start in the same cycle → no swap until the next frame_start.
  - init_identity and commit in IDLE → fill runs, commit is ignored, and IDLE follows.
- Reset mid-fill at n+300 → ram_we=0 and active_bank=0 at n+301, state IDLE, host_rdy=1 after release.
